// File: rtl/arbitro_esteira.sv
// Shared conveyor-motor arbiter: round-robin grant of one motor among three
// destination requests, with alarm pause, movement timeout and done handshake.
module arbitro_esteira #(
  parameter int TIMEOUT_CICLOS = 500000000,
  parameter int TIMER_W        = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] sensor,
  input  logic       alarme_rolha,
  output logic       motor_ativo,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       ocupado,
  output logic       erro_timeout
);

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] MOVENDO   = 3'd1;
  localparam logic [2:0] PAUSADO   = 3'd2;
  localparam logic [2:0] CONCLUIDO = 3'd3;
  localparam logic [2:0] ERRO      = 3'd4;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CICLOS - 1);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         sync1_q, sync2_q;
  logic               motor_q;
  logic [2:0]         done_q;
  logic               ocupado_q;
  logic               erro_q;

  logic [1:0] cand [3];
  logic       win_valid;
  logic [1:0] win_idx;
  logic       req_g;
  logic       sens_g;

  function automatic logic [1:0] rr_step(input logic [1:0] p, input int n);
    int s;
    s = (int'(p) + n) % 3;
    return s[1:0];
  endfunction

  // cand[0] is the highest-priority index: the one right after the last winner
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    assign cand[gi] = rr_step(ptr_q, gi + 1);
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      if (req[cand[k]]) begin
        win_valid = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  assign req_g  = |(req & grant_q);
  assign sens_g = |(sync2_q & grant_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      OCIOSO: begin
        if (win_valid && !alarme_rolha) begin
          grant_d = 3'b001 << win_idx;
          ptr_d   = win_idx;
          timer_d = '0;
          state_d = MOVENDO;
        end
      end
      MOVENDO: begin
        if (!req_g) begin
          state_d = OCIOSO;
          grant_d = '0;
        end else if (sens_g) begin
          state_d = CONCLUIDO;
        end else if (alarme_rolha) begin
          state_d = PAUSADO;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ERRO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PAUSADO: begin
        if (!req_g) begin
          state_d = OCIOSO;
          grant_d = '0;
        end else if (!alarme_rolha) begin
          state_d = MOVENDO;
        end
      end
      CONCLUIDO, ERRO: begin
        if (!req_g) begin
          state_d = OCIOSO;
          grant_d = '0;
        end
      end
      default: begin
        state_d = OCIOSO;
        grant_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      timer_q   <= '0;
      ptr_q     <= 2'd2;
      grant_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      motor_q   <= 1'b0;
      done_q    <= '0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      sync1_q   <= sensor;
      sync2_q   <= sync1_q;
      motor_q   <= (state_d == MOVENDO);
      done_q    <= (state_d == CONCLUIDO) ? grant_d : 3'b000;
      ocupado_q <= (state_d != OCIOSO);
      erro_q    <= (state_d == ERRO);
    end
  end

  assign motor_ativo  = motor_q;
  assign grant        = grant_q;
  assign done         = done_q;
  assign ocupado      = ocupado_q;
  assign erro_timeout = erro_q;

endmodule

// File: tb/tb_arbitro_esteira.sv
// Bench for arbitro_esteira: directed table, hand-written corner sequences and
// a randomized run against a behavioural owner/phase model.
module tb_arbitro_esteira;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] sensor = '0;
  logic       alarme_rolha = 1'b0;
  logic       motor_ativo;
  logic [2:0] grant;
  logic [2:0] done;
  logic       ocupado;
  logic       erro_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  arbitro_esteira #(.TIMEOUT_CICLOS(T), .TIMER_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .sensor(sensor),
    .alarme_rolha(alarme_rolha), .motor_ativo(motor_ativo), .grant(grant),
    .done(done), .ocupado(ocupado), .erro_timeout(erro_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] sens;
    logic       alarm;
    logic [2:0] g;
    logic       m;
    logic [2:0] d;
    logic       o;
    logic       e;
  } vec_t;

  vec_t tbl [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // word layout: {grant, done, motor, ocupado, erro}
  function automatic logic [31:0] outw();
    return {23'd0, grant, done, motor_ativo, ocupado, erro_timeout};
  endfunction

  function automatic logic [31:0] mkw(input logic [2:0] g, input logic [2:0] d,
                                      input logic m, input logic o, input logic e);
    return {23'd0, g, d, m, o, e};
  endfunction

  // behavioural reference for the random phase
  int         m_owner;
  int         m_ptr;
  int         m_moves;
  bit         m_fin, m_fail, m_pause;
  logic [2:0] m_s1, m_s2;

  task automatic model_reset();
    m_owner = -1; m_ptr = 2; m_moves = 0;
    m_fin = 0; m_fail = 0; m_pause = 0;
    m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] pin, input logic a);
    logic [2:0] seen;
    int w;
    seen = m_s2;
    if (m_owner < 0) begin
      if (r != 0 && !a) begin
        w = -1;
        for (int k = 1; k <= 3; k++)
          if (w < 0 && r[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        m_owner = w; m_ptr = w; m_moves = 0;
        m_fin = 0; m_fail = 0; m_pause = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_fin || m_fail) begin
    end else if (m_pause) begin
      if (!a) m_pause = 0;
    end else if (seen[m_owner]) begin
      m_fin = 1;
    end else if (a) begin
      m_pause = 1;
    end else if (m_moves == T - 1) begin
      m_fail = 1;
    end else begin
      m_moves++;
    end
    m_s2 = m_s1;
    m_s1 = pin;
  endtask

  function automatic logic [31:0] model_w();
    logic [2:0] g;
    bit act;
    act = (m_owner >= 0);
    g = act ? (3'b001 << m_owner) : 3'b000;
    return mkw(g, (act && m_fin) ? g : 3'b000,
               act && !m_fin && !m_fail && !m_pause, act, act && m_fail);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int ok;
    logic [2:0] order [4];
    logic [2:0] exp_order [4];
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;

    tbl[0]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[1]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[2]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[3]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[4]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[5]  = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[6]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[7]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0};
    tbl[8]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0};
    tbl[9]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[11] = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[12] = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[13] = '{3'b010, 3'b000, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
    tbl[14] = '{3'b110, 3'b000, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
    tbl[15] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[16] = '{3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[17] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

    reset = 1'b0;
    tick(); tick();
    check("reset_state", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    tick();
    check("idle_after_reset", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req; sensor = tbl[i].sens; alarme_rolha = tbl[i].alarm;
      tick();
      check($sformatf("table_row%0d", i), outw(),
            mkw(tbl[i].g, tbl[i].d, tbl[i].m, tbl[i].o, tbl[i].e));
      $display("table row %0d req=%b sens=%b -> grant=%b done=%b motor=%b", i,
               tbl[i].req, tbl[i].sens, grant, done, motor_ativo);
    end

    // round robin with all three requests held
    req = 3'b111; sensor = '0;
    for (int n = 0; n < 4; n++) begin
      cnt = 0;
      while (grant == 3'b000 && cnt < 5) begin tick(); cnt++; end
      order[n] = grant;
      check($sformatf("rr_order%0d", n), grant, exp_order[n]);
      sensor = grant;
      cnt = 0;
      while (done == 3'b000 && cnt < 10) begin tick(); cnt++; end
      check($sformatf("rr_done%0d", n), done, order[n]);
      req = req & ~order[n]; sensor = '0;
      tick();
      check($sformatf("rr_release%0d", n), {grant, done}, 6'd0);
      req = 3'b111;
      $display("rr step %0d grant=%b", n, order[n]);
    end
    req = '0;
    tick(); tick(); tick();

    // timeout: pointer=0, so req 001 wins
    req = 3'b001;
    tick();
    check("to_grant", outw(), mkw(3'b001, 3'b000, 1'b1, 1'b1, 1'b0));
    cnt = 1;
    while (motor_ativo && cnt < 40) begin tick(); if (motor_ativo) cnt++; end
    check("to_move_cycles", cnt, T);
    check("to_erro", outw(), mkw(3'b001, 3'b000, 1'b0, 1'b1, 1'b1));
    tick();
    check("to_erro_held", outw(), mkw(3'b001, 3'b000, 1'b0, 1'b1, 1'b1));
    req = '0;
    tick();
    check("to_release", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    $display("timeout sequence moving cycles=%0d", cnt);

    // alarm pause after 8 counted cycles
    req = 3'b010;
    tick();
    for (int k = 0; k < 7; k++) tick();
    check("pause_moving", outw(), mkw(3'b010, 3'b000, 1'b1, 1'b1, 1'b0));
    alarme_rolha = 1'b1;
    ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (motor_ativo !== 1'b0 || erro_timeout !== 1'b0 || grant !== 3'b010) ok = 0;
    end
    check("pause_motor_off", ok, 1);
    alarme_rolha = 1'b0;
    tick();
    check("pause_resume", outw(), mkw(3'b010, 3'b000, 1'b1, 1'b1, 1'b0));
    tick(); tick(); tick();
    sensor = 3'b010;
    cnt = 0;
    while (done == 3'b000 && erro_timeout == 1'b0 && cnt < 10) begin tick(); cnt++; end
    check("pause_done", outw(), mkw(3'b010, 3'b010, 1'b0, 1'b1, 1'b0));
    req = '0; sensor = '0;
    tick(); tick(); tick();
    $display("pause sequence done after %0d cycles", cnt);

    // abort mid-move
    req = 3'b010;
    tick(); tick(); tick();
    check("abort_moving", outw(), mkw(3'b010, 3'b000, 1'b1, 1'b1, 1'b0));
    req = '0;
    tick();
    check("abort_off", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    $display("abort sequence grant cleared");

    // sensor already high at grant
    sensor = 3'b100;
    tick(); tick(); tick();
    req = 3'b100;
    tick();
    check("presens_motor", outw(), mkw(3'b100, 3'b000, 1'b1, 1'b1, 1'b0));
    tick();
    check("presens_done", outw(), mkw(3'b100, 3'b100, 1'b0, 1'b1, 1'b0));
    req = '0; sensor = '0;
    tick();
    check("presens_release", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    $display("sensor-already-set sequence complete");

    // bring pointer to 0, then req 101 must pick index 2
    sensor = 3'b001;
    tick(); tick(); tick();
    req = 3'b001;
    tick(); tick();
    check("ptr0_done", done, 3'b001);
    req = '0; sensor = '0;
    tick(); tick(); tick();
    req = 3'b101;
    tick();
    check("ptr0_req101", grant, 3'b100);
    req = '0;
    tick();
    $display("pointer=0 req=101 grant=100 sequence complete");

    // asynchronous reset while moving; pointer then back to 2
    req = 3'b001;
    tick(); tick();
    check("arst_pre", motor_ativo, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_immediate", outw(), mkw(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    req = 3'b011;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("arst_ptr_reset", grant, 3'b001);
    req = '0;
    tick();
    $display("async reset sequence complete");

    // randomized run against the reference model
    reset = 1'b0; sensor = '0; alarme_rolha = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] r;
      r = req;
      for (int i = 0; i < 3; i++) begin
        if (!r[i]) begin
          if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
        end else if (done[i] || erro_timeout && grant[i]) begin
          if ($urandom_range(0, 1) == 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          r[i] = 1'b0;
        end
      end
      req = r;
      if ($urandom_range(0, 5) == 0) sensor = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) alarme_rolha = ~alarme_rolha;
      @(posedge clk);
      model_step(req, sensor, alarme_rolha);
      #1;
      check($sformatf("rand_cycle%0d", c), outw(), model_w());
      if (c % 250 == 0)
        $display("random cycle %0d req=%b sens=%b alarm=%b grant=%b done=%b motor=%b err=%b",
                 c, req, sensor, alarme_rolha, grant, done, motor_ativo, erro_timeout);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
